osc_scan_mixer: RTL and testbench

OSC_SCAN_MIXER -- requirements
Module: osc_scan_mixer

---
 rtl/osc_scan_mixer_pkg.sv | 33 +++
 rtl/osc_scan_mixer_if.sv | 26 ++
 rtl/osc_scan_mixer_tag_pipe.sv | 35 +++
 rtl/osc_scan_mixer.sv | 184 ++++++++++++++++++
 tb/tb_osc_scan_mixer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/osc_scan_mixer_pkg.sv
// Shared constants, default widths and FSM encoding for the oscillator scan mixer.
package osc_scan_mixer_pkg;

   localparam int VOICES_DEF   = 8;
   localparam int V_OSC_DEF    = 4;
   localparam int V_WIDTH_DEF  = 3;
   localparam int O_WIDTH_DEF  = 2;
   localparam int OE_WIDTH_DEF = 1;
   localparam int LAT_DEF      = 2;

   localparam int LVL_ADR_BASE  = 7;
   localparam int LVL_ADR_SHIFT = 4;
   localparam int ADR_W         = 7;
   localparam int LVL_W         = 8;
   localparam int SAMPLE_W      = 17;
   localparam int PROD_W        = SAMPLE_W + LVL_W;
   localparam int PROD_SHIFT    = 7;
   localparam int TERM_W        = 18;
   localparam int MIX_W         = 20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Four 18-bit terms fit in 20 bits; wider voices need one extra bit per doubling.
   function automatic int acc_width(input int v_osc);
      return (v_osc > 4) ? TERM_W + $clog2(v_osc) : MIX_W;
   endfunction

endpackage

// File: rtl/osc_scan_mixer_if.sv
// Level-register write port (master drives) and per-voice mix result (slave drives).
interface osc_scan_mixer_if
   import osc_scan_mixer_pkg::*;
#(
   parameter int V_WIDTH = V_WIDTH_DEF
) ();

   logic [LVL_W-1:0]        data;
   logic [ADR_W-1:0]        adr;
   logic                    write;
   logic                    osc_sel;
   logic signed [MIX_W-1:0] mix_data;
   logic [V_WIDTH-1:0]      mix_vx;
   logic                    mix_valid;

   modport master (
      output data, adr, write, osc_sel,
      input  mix_data, mix_vx, mix_valid
   );

   modport slave (
      input  data, adr, write, osc_sel,
      output mix_data, mix_vx, mix_valid
   );

endinterface

// File: rtl/osc_scan_mixer_tag_pipe.sv
// LAT-deep delay line that carries each issued scan tag alongside the sine LUT latency.
module osc_tag_pipe #(
   parameter int LAT   = 2,
   parameter int TAG_W = 7
) (
   input  logic             iRST_N,
   input  logic             sCLK_XVXOSC,
   input  logic [TAG_W-1:0] tag_in,
   output logic [TAG_W-1:0] tag_out
);

   logic [TAG_W-1:0] pipe_q [LAT];
   logic [TAG_W-1:0] pipe_d [LAT];

   always_comb begin
      pipe_d[0] = tag_in;
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // NOTE: flops take <= so every stage samples the pre-edge value of its neighbour.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/osc_scan_mixer.sv
// Scans VOICES x V_OSC oscillator indices per frame and sums level-scaled sine samples per voice.
// Define OSC_SCAN_SAT_EN to clamp mix_data to the signed 16-bit range.
module osc_scan_mixer
   import osc_scan_mixer_pkg::*;
#(
   parameter int  VOICES   = VOICES_DEF,
   parameter int  V_OSC    = V_OSC_DEF,
   parameter int  V_WIDTH  = V_WIDTH_DEF,
   parameter int  O_WIDTH  = O_WIDTH_DEF,
   parameter int  OE_WIDTH = OE_WIDTH_DEF,
   parameter int  LAT      = LAT_DEF,
   localparam int E_WIDTH  = O_WIDTH + OE_WIDTH
) (
   input  logic                        iRST_N,
   input  logic                        sCLK_XVXOSC,
   input  logic                        frame_start,
   output logic                        busy,
   osc_scan_mixer_if.slave             lvl_bus,
   output logic [V_WIDTH+E_WIDTH-1:0]  xxxx,
   input  logic signed [SAMPLE_W-1:0]  sine_lut_out,
   output logic                        frame_done
);

   localparam int ACC_W = acc_width(V_OSC);
   localparam int TAG_W = V_WIDTH + O_WIDTH + 2;
   localparam int DC_W  = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [V_WIDTH-1:0] VX_LAST = V_WIDTH'(VOICES - 1);
   localparam logic [O_WIDTH-1:0] OX_LAST = O_WIDTH'(V_OSC - 1);
   localparam logic [DC_W-1:0]    DC_LAST = DC_W'(LAT - 1);
`ifdef OSC_SCAN_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);
`endif

   state_e                   state_q, state_d;
   logic [V_WIDTH-1:0]       vx_q, vx_d;
   logic [O_WIDTH-1:0]       ox_q, ox_d;
   logic [DC_W-1:0]          dc_q, dc_d;
   logic [LVL_W-1:0]         lvl_q [V_OSC];
   logic [LVL_W-1:0]         lvl_d [V_OSC];
   logic [LVL_W-1:0]         shd_q [V_OSC];
   logic [LVL_W-1:0]         shd_d [V_OSC];
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_sum;
   logic signed [TERM_W-1:0] term;
   logic signed [MIX_W-1:0]  mix_data_q, mix_data_d, mix_sum;
   logic [V_WIDTH-1:0]       mix_vx_q, mix_vx_d;
   logic                     mix_valid_q, mix_valid_d;
   logic                     accept, last_idx;
   logic [TAG_W-1:0]         tag_in, tag_out;
   logic                     t_valid, t_last;
   logic [V_WIDTH-1:0]       t_vx;
   logic [O_WIDTH-1:0]       t_ox;

   assign accept   = (state_q == ST_IDLE) && frame_start;
   assign last_idx = (vx_q == VX_LAST) && (ox_q == OX_LAST);

   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (frame_start)     state_d = ST_SCAN;
         ST_SCAN:  if (last_idx)        state_d = ST_DRAIN;
         ST_DRAIN: if (dc_q == DC_LAST) state_d = ST_DONE;
         ST_DONE:                       state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      vx_d = vx_q;
      ox_d = ox_q;
      dc_d = (state_q == ST_DRAIN) ? dc_q + 1'b1 : '0;
      if (accept) begin
         vx_d = '0;
         ox_d = '0;
      end else if ((state_q == ST_SCAN) && !last_idx) begin
         if (ox_q == OX_LAST) begin
            ox_d = '0;
            vx_d = vx_q + 1'b1;
         end else begin
            ox_d = ox_q + 1'b1;
         end
      end
   end

   // Writes land in lvl; the shadow copy taken at frame acceptance is what the scan uses.
   always_comb begin
      lvl_d = lvl_q;
      shd_d = shd_q;
      if (accept) shd_d = lvl_q;
      for (int o = 0; o < V_OSC; o++) begin
         if (lvl_bus.write && lvl_bus.osc_sel &&
             (lvl_bus.adr == ADR_W'(LVL_ADR_BASE + (o << LVL_ADR_SHIFT)))) begin
            lvl_d[o] = lvl_bus.data;
         end
      end
   end

   assign tag_in = {state_q == ST_SCAN, vx_q, ox_q, ox_q == OX_LAST};

   osc_tag_pipe #(
      .LAT   (LAT),
      .TAG_W (TAG_W)
   ) u_tag_pipe (
      .iRST_N      (iRST_N),
      .sCLK_XVXOSC (sCLK_XVXOSC),
      .tag_in      (tag_in),
      .tag_out     (tag_out)
   );

   assign t_valid = tag_out[TAG_W-1];
   assign t_vx    = tag_out[TAG_W-2 -: V_WIDTH];
   assign t_ox    = tag_out[1 +: O_WIDTH];
   assign t_last  = tag_out[0];

   always_comb begin
      term     = TERM_W'((PROD_W'(sine_lut_out) * PROD_W'($signed({1'b0, shd_q[t_ox]})))
                         >>> PROD_SHIFT);
      acc_base = (t_ox == '0) ? '0 : acc_q;
      acc_sum  = acc_base + ACC_W'(term);
`ifdef OSC_SCAN_SAT_EN
      if (acc_sum > SAT_HI)      mix_sum = MIX_W'(SAT_HI);
      else if (acc_sum < SAT_LO) mix_sum = MIX_W'(SAT_LO);
      else                       mix_sum = MIX_W'(acc_sum);
`else
      mix_sum = MIX_W'(acc_sum);
`endif
      acc_d       = acc_q;
      mix_data_d  = mix_data_q;
      mix_vx_d    = mix_vx_q;
      mix_valid_d = 1'b0;
      if (t_valid) begin
         acc_d = acc_sum;
         if (t_last) begin
            mix_valid_d = 1'b1;
            mix_data_d  = mix_sum;
            mix_vx_d    = t_vx;
         end
      end
   end

   // NOTE: the level arrays are reset in full; a reset must leave every level reading zero.
   always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         vx_q        <= '0;
         ox_q        <= '0;
         dc_q        <= '0;
         acc_q       <= '0;
         mix_data_q  <= '0;
         mix_vx_q    <= '0;
         mix_valid_q <= 1'b0;
         for (int o = 0; o < V_OSC; o++) begin
            lvl_q[o] <= '0;
            shd_q[o] <= '0;
         end
      end else begin
         vx_q        <= vx_d;
         ox_q        <= ox_d;
         dc_q        <= dc_d;
         acc_q       <= acc_d;
         mix_data_q  <= mix_data_d;
         mix_vx_q    <= mix_vx_d;
         mix_valid_q <= mix_valid_d;
         lvl_q       <= lvl_d;
         shd_q       <= shd_d;
      end
   end

   assign xxxx              = {vx_q, ox_q, {OE_WIDTH{1'b0}}};
   assign lvl_bus.mix_data  = mix_data_q;
   assign lvl_bus.mix_vx    = mix_vx_q;
   assign lvl_bus.mix_valid = mix_valid_q;

endmodule

// File: tb/tb_osc_scan_mixer.sv
// Randomised bench for osc_scan_mixer with a frame-level reference model and directed cases.
`timescale 1ns/1ps
module tb_osc_scan_mixer;

   localparam int VOICES   = 8;
   localparam int V_OSC    = 4;
   localparam int V_WIDTH  = 3;
   localparam int O_WIDTH  = 2;
   localparam int OE_WIDTH = 1;
   localparam int LAT      = 2;
   localparam int XW       = V_WIDTH + O_WIDTH + OE_WIDTH;
   localparam int NIDX     = VOICES * V_OSC;

   logic                iRST_N      = 1'b0;
   logic                sCLK_XVXOSC = 1'b0;
   logic                frame_start = 1'b0;
   logic                busy, frame_done;
   logic [XW-1:0]       xxxx;
   logic signed [16:0]  sine_lut_out = '0;

   osc_scan_mixer_if #(.V_WIDTH(V_WIDTH)) bus ();

   osc_scan_mixer #(
      .VOICES   (VOICES),
      .V_OSC    (V_OSC),
      .V_WIDTH  (V_WIDTH),
      .O_WIDTH  (O_WIDTH),
      .OE_WIDTH (OE_WIDTH),
      .LAT      (LAT)
   ) dut (
      .iRST_N       (iRST_N),
      .sCLK_XVXOSC  (sCLK_XVXOSC),
      .frame_start  (frame_start),
      .busy         (busy),
      .lvl_bus      (bus),
      .xxxx         (xxxx),
      .sine_lut_out (sine_lut_out),
      .frame_done   (frame_done)
   );

   always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_done   = 0;

   bit active = 1'b0;
   int a_cyc  = 0;
   int lvl_m   [V_OSC];
   int shd_m   [V_OSC];
   int lut_m   [NIDX];
   int exp_mix [VOICES];
   int dut_mix [VOICES];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat_mix(input int s);
`ifdef OSC_SCAN_SAT_EN
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
`endif
      return s;
   endfunction

   function automatic int voice_sum(input int v);
      int s = 0;
      for (int o = 0; o < V_OSC; o++) s += (lut_m[v*V_OSC + o] * shd_m[o]) >>> 7;
      return sat_mix(s);
   endfunction

   // Sine LUT environment: each index comes back LAT cycles after it was presented.
   logic [XW-1:0] xh [$];
   always @(negedge sCLK_XVXOSC) begin
      xh.push_back(xxxx);
      if (xh.size() > LAT + 1) xh.delete(0);
      if (xh.size() == LAT + 1) sine_lut_out = 17'(lut_m[xh[0] >> OE_WIDTH]);
   end

   // Frame-level reference model: acceptance, shadow snapshot, level writes.
   always @(posedge sCLK_XVXOSC or negedge iRST_N) begin
      if (!iRST_N) begin
         active = 1'b0;
         for (int o = 0; o < V_OSC; o++) begin
            lvl_m[o] = 0;
            shd_m[o] = 0;
         end
      end else begin
         cyc++;
         if (frame_start && (!active || cyc >= a_cyc + NIDX + LAT + 2)) begin
            active = 1'b1;
            a_cyc  = cyc;
            shd_m  = lvl_m;
            for (int v = 0; v < VOICES; v++) exp_mix[v] = voice_sum(v);
         end
         if (bus.write && bus.osc_sel) begin
            for (int o = 0; o < V_OSC; o++)
               if (int'(bus.adr) == 7 + (o << 4)) lvl_m[o] = int'(bus.data);
         end
      end
   end

   int rel, e_v;
   bit e_busy, e_done, e_valid;
   always @(negedge sCLK_XVXOSC) begin
      if (!iRST_N) begin
         check("rst_busy", busy, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_mix_valid", bus.mix_valid, 0);
         check("rst_mix_data", bus.mix_data, 0);
         check("rst_mix_vx", bus.mix_vx, 0);
         check("rst_xxxx", xxxx, 0);
      end else begin
         rel     = cyc - a_cyc;
         e_busy  = active && rel >= 0 && rel <= NIDX - 1 + LAT;
         e_done  = active && rel == NIDX + LAT;
         e_valid = active && rel >= V_OSC + LAT && rel <= NIDX + LAT && ((rel - LAT) % V_OSC) == 0;
         check("busy", busy, e_busy);
         check("frame_done", frame_done, e_done);
         check("mix_valid", bus.mix_valid, e_valid);
         if (e_valid) begin
            e_v = (rel - LAT) / V_OSC - 1;
            check("mix_vx", bus.mix_vx, e_v);
            check("mix_data", bus.mix_data, exp_mix[e_v]);
         end
         if (active && rel >= 0 && rel < NIDX)
            check("xxxx", xxxx, ((rel / V_OSC) << (O_WIDTH + OE_WIDTH)) | ((rel % V_OSC) << OE_WIDTH));
         if (bus.mix_valid) begin
            n_valid++;
            dut_mix[bus.mix_vx] = bus.mix_data;
         end
         if (frame_done) n_done++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sCLK_XVXOSC);
   endtask

   task automatic wr_lvl(input int o, input int val);
      @(negedge sCLK_XVXOSC);
      bus.write   = 1'b1;
      bus.osc_sel = 1'b1;
      bus.adr     = 7'(7 + (o << 4));
      bus.data    = 8'(val);
      @(negedge sCLK_XVXOSC);
      bus.write   = 1'b0;
      bus.osc_sel = 1'b0;
   endtask

   task automatic fill_lut(input int val);
      foreach (lut_m[i]) lut_m[i] = val;
   endtask

   task automatic rand_lut();
      logic [16:0] r;
      foreach (lut_m[i]) begin
         r        = 17'($urandom);
         lut_m[i] = int'($signed(r));
      end
   endtask

   task automatic begin_frame();
      n_valid = 0;
      n_done  = 0;
      foreach (dut_mix[v]) dut_mix[v] = 999999;
      @(negedge sCLK_XVXOSC);
      frame_start = 1'b1;
      @(negedge sCLK_XVXOSC);
      frame_start = 1'b0;
   endtask

   task automatic expect_frame(input string name, input int val);
      check({name, "_n_valid"}, n_valid, VOICES);
      check({name, "_n_done"}, n_done, 1);
      for (int v = 0; v < VOICES; v++) check({name, "_mix"}, dut_mix[v], val);
   endtask

   task automatic rand_bus();
      bus.write   = ($urandom_range(0, 3) == 0);
      bus.osc_sel = ($urandom_range(0, 3) != 0);
      bus.adr     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(7 + ($urandom_range(0, V_OSC - 1) << 4));
      bus.data    = 8'($urandom);
   endtask

   initial begin
      bus.data = '0; bus.adr = '0; bus.write = 1'b0; bus.osc_sel = 1'b0;
      fill_lut(1000);
      tick(3);
      #2 iRST_N = 1'b1;

      // All levels 128, sine 1000: each voice 4 x 1000.
      for (int o = 0; o < V_OSC; o++) wr_lvl(o, 128);
      begin_frame();
      tick(NIDX + LAT + 4);
      expect_frame("lvl128", 4000);

      // Only lvl[0]=255, sine at negative full scale.
      wr_lvl(0, 255);
      for (int o = 1; o < V_OSC; o++) wr_lvl(o, 0);
      fill_lut(-65536);
      begin_frame();
      tick(NIDX + LAT + 4);
`ifdef OSC_SCAN_SAT_EN
      expect_frame("negfs", -32768);
`else
      expect_frame("negfs", -130560);
`endif

      // Extra frame_start requests during SCAN are ignored.
      for (int o = 0; o < V_OSC; o++) wr_lvl(o, 128);
      fill_lut(1000);
      begin_frame();
      tick(5);
      frame_start = 1'b1;
      tick(3);
      frame_start = 1'b0;
      tick(NIDX + LAT);
      expect_frame("restart_ignored", 4000);

      // Mid-frame level write affects only the following frame.
      begin_frame();
      tick(6);
      wr_lvl(2, 64);
      tick(NIDX + LAT);
      expect_frame("midwr_old", 4000);
      begin_frame();
      tick(NIDX + LAT + 4);
      expect_frame("midwr_new", 3500);

      // Reset after 10 SCAN cycles aborts the frame and clears the levels.
      begin_frame();
      tick(10);
      #2 iRST_N = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_xxxx", xxxx, 0);
      check("abort_mix_valid", bus.mix_valid, 0);
      check("abort_mix_data", bus.mix_data, 0);
      check("abort_mix_vx", bus.mix_vx, 0);
      check("abort_frame_done", frame_done, 0);
      @(negedge sCLK_XVXOSC);
      #2 iRST_N = 1'b1;
      n_valid = 0;
      tick(NIDX + LAT + 4);
      check("abort_no_valid", n_valid, 0);
      begin_frame();
      tick(NIDX + LAT + 4);
      expect_frame("post_rst_zero_lvl", 0);
      for (int o = 0; o < V_OSC; o++) wr_lvl(o, 128);
      begin_frame();
      tick(NIDX + LAT + 4);
      expect_frame("post_rst", 4000);

      // Randomised frames: random samples, levels, writes and stray frame requests.
      for (int f = 0; f < 24; f++) begin
         rand_lut();
         for (int o = 0; o < V_OSC; o++)
            if ($urandom_range(0, 1) == 1) wr_lvl(o, int'($urandom_range(0, 255)));
         @(negedge sCLK_XVXOSC);
         frame_start = 1'b1;
         for (int c = 0; c < NIDX + LAT + 6; c++) begin
            @(negedge sCLK_XVXOSC);
            frame_start = ($urandom_range(0, 7) == 0);
            rand_bus();
         end
         frame_start = 1'b0;
         bus.write   = 1'b0;
         tick(NIDX + LAT + 4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
